// File: rtl/pc_unit_ras.sv
// -----------------------------------------------------------------------------
// pc_unit_ras
//
// Next-PC generator for the multicycle core. Holds the architectural PC and
// the exception PC (EPC), and contains a small circular return-address stack
// (RAS) that predicts return targets for jr-style returns.
//
// The next PC is chosen from seven sources. An exception request overrides
// the source select and forces a PC load.
//
// Parameters
//   RESET_PC    : PC value after reset
//   EXC_VECTOR  : exception entry address
//   RAS_DEPTH   : number of RAS entries (power of two, >= 2)
//
// Ports
//   i_clk          : clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_pc_write     : load o_next_pc into o_pc at this edge
//   i_pc_src[2:0]  : next-PC source select
//   i_alu_out      : current ALU result (PC+4 during fetch)
//   i_alu_out_reg  : registered ALU result (branch target)
//   i_jump_addr    : instruction[25:0] for j/jal
//   i_rs_data      : register-file rs value (jr target, RAS fallback)
//   i_ras_push     : push the current PC onto the RAS
//   i_exc_req      : exception request, overrides i_pc_src/i_pc_write
//   o_pc           : PC register
//   o_next_pc      : combinational selected next PC
//   o_epc          : exception PC register
//   o_ras_count    : number of valid RAS entries
//   o_ras_empty    : RAS holds no entries
//   o_ras_full     : RAS holds RAS_DEPTH entries
//   o_misaligned   : o_next_pc is not word aligned (advisory only)
// -----------------------------------------------------------------------------
module pc_unit_ras #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_pc_write,
    input  logic [2:0]                   i_pc_src,
    input  logic [31:0]                  i_alu_out,
    input  logic [31:0]                  i_alu_out_reg,
    input  logic [25:0]                  i_jump_addr,
    input  logic [31:0]                  i_rs_data,
    input  logic                         i_ras_push,
    input  logic                         i_exc_req,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_next_pc,
    output logic [31:0]                  o_epc,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ras_empty,
    output logic                         o_ras_full,
    output logic                         o_misaligned
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] SRC_INC  = 3'b000;
    localparam logic [2:0] SRC_BR   = 3'b001;
    localparam logic [2:0] SRC_J    = 3'b010;
    localparam logic [2:0] SRC_JR   = 3'b011;
    localparam logic [2:0] SRC_RAS  = 3'b100;
    localparam logic [2:0] SRC_EXC  = 3'b101;
    localparam logic [2:0] SRC_ERET = 3'b110;
    localparam logic [2:0] SRC_INC2 = 3'b111;

    localparam logic [CW-1:0] COUNT_MAX = CW'(RAS_DEPTH);

    // Architectural state
    logic [31:0]   r_pc;
    logic [31:0]   r_epc;
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_count;
    logic [31:0]   r_ras [RAS_DEPTH];

    // Combinational helpers
    logic [31:0]   w_next_pc;
    logic [31:0]   w_ras_top;
    logic          w_ras_valid;
    logic          w_ras_full;
    logic          w_pop_req;
    logic          w_pop;
    logic          w_replace;
    logic          w_push;
    logic          w_pop_only;
    logic [PW-1:0] w_top_inc;
    logic [PW-1:0] w_top_dec;
    logic [PW-1:0] w_wr_idx;
    logic          w_pc_load;
    logic          w_epc_load;

    assign w_ras_top   = r_ras[r_top];
    assign w_ras_valid = (r_count != '0);
    assign w_ras_full  = (r_count == COUNT_MAX);

    assign w_top_inc = r_top + 1'b1;
    assign w_top_dec = r_top - 1'b1;

    // A pop only happens on an actual PC load from the RAS source, and an
    // exception in the same cycle cancels it.
    assign w_pop_req = (i_pc_src == SRC_RAS) && i_pc_write && !i_exc_req;
    assign w_pop     = w_pop_req && w_ras_valid;

    // Push and pop together: the return consumes the old top and the call
    // deposits its link in the same slot, so depth is unchanged. On an empty
    // stack there is nothing to consume and it degenerates into a plain push.
    assign w_replace  = i_ras_push && w_pop;
    assign w_push     = i_ras_push && !w_pop;
    assign w_pop_only = w_pop && !i_ras_push;

    assign w_wr_idx = w_replace ? r_top : w_top_inc;

    assign w_pc_load  = i_pc_write || i_exc_req;
    assign w_epc_load = i_exc_req || ((i_pc_src == SRC_EXC) && i_pc_write);

    // Next-PC selection; the exception request overrides the source select.
    always_comb begin
        w_next_pc = i_alu_out;
        if (i_exc_req) begin
            w_next_pc = EXC_VECTOR;
        end else begin
            case (i_pc_src)
                SRC_INC:  w_next_pc = i_alu_out;
                SRC_BR:   w_next_pc = i_alu_out_reg;
                SRC_J:    w_next_pc = {r_pc[31:28], i_jump_addr, 2'b00};
                SRC_JR:   w_next_pc = i_rs_data;
                SRC_RAS:  w_next_pc = w_ras_valid ? w_ras_top : i_rs_data;
                SRC_EXC:  w_next_pc = EXC_VECTOR;
                SRC_ERET: w_next_pc = r_epc;
                SRC_INC2: w_next_pc = i_alu_out;
                default:  w_next_pc = i_alu_out;
            endcase
        end
    end

    // PC and EPC registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc  <= RESET_PC;
            r_epc <= '0;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_epc_load) begin
                r_epc <= r_pc;
            end
        end
    end

    // RAS pointer and occupancy. When full, a push still advances the top and
    // thereby overwrites the oldest entry; the count simply saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_top <= w_top_inc;
            if (!w_ras_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop_only) begin
            r_top   <= w_top_dec;
            r_count <= r_count - 1'b1;
        end
    end

    // RAS storage. Contents are don't-care after reset, so the array carries
    // no reset and maps onto plain distributed storage.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_ras_push) begin
            r_ras[w_wr_idx] <= r_pc;
        end
    end

    assign o_pc         = r_pc;
    assign o_next_pc    = w_next_pc;
    assign o_epc        = r_epc;
    assign o_ras_count  = r_count;
    assign o_ras_empty  = !w_ras_valid;
    assign o_ras_full   = w_ras_full;
    assign o_misaligned = (w_next_pc[1:0] != 2'b00);

endmodule

// File: doc/pc_unit_ras.md
# pc_unit_ras

Parametrised successor to the multicycle next-PC generator. Holds the architectural PC register and selects the next PC from seven sources: incremented PC, branch target, jump, jump-register, return-address-stack pop, exception vector and exception return. It also contains a circular return-address stack (RAS) and an EPC register. It sits between the multicycle control FSM (which drives `pc_write`, `pc_src`, `ras_push`, `exc_req`) and the instruction-memory address port.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `EXC_VECTOR`, default 32'h0000_0180: exception entry address.
- `RAS_DEPTH`, default 4: number of RAS entries; must be a power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pc_write` in 1: load `next_pc` into `pc` at this edge.
- `pc_src` in 3: next-PC source select (see Operation).
- `alu_out` in 32: current ALU result (PC+4 during fetch).
- `alu_out_reg` in 32: registered ALU result (branch target).
- `jump_addr` in 26: instruction[25:0].
- `rs_data` in 32: register-file rs value (jr target).
- `ras_push` in 1: push the current `pc` (jal/jalr executing; `pc` already holds PC+4).
- `exc_req` in 1: exception request; overrides `pc_src` and `pc_write`.
- `pc` out 32: PC register.
- `next_pc` out 32: combinational selected next PC.
- `epc` out 32: exception PC register.
- `ras_count` out clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_empty`, `ras_full` out 1: `ras_count`==0 and `ras_count`==RAS_DEPTH.
- `misaligned` out 1: `next_pc[1:0]`!=0 (combinational).

## Operation
- `next_pc` mux, highest priority first:
  - `exc_req`=1 → `EXC_VECTOR`.
  - Otherwise by `pc_src`:
    - 000 → `alu_out`
    - 001 → `alu_out_reg`
    - 010 → {`pc`[31:28], `jump_addr`, 2'b00}
    - 011 → `rs_data`
    - 100 → RAS top if `ras_count`>0, else `rs_data` (fallback)
    - 101 → `EXC_VECTOR`
    - 110 → `epc`
    - 111 → `alu_out`
- PC register: at the edge, `pc` <= `next_pc` if `pc_write` or `exc_req`; otherwise it holds.
- EPC: at the edge, `epc` <= `pc` if `exc_req`=1, or if `pc_src`=101 with `pc_write`=1. EPC is otherwise unchanged and is not altered by eret (110).
- RAS is a circular buffer with a top pointer and a count.
- Push (`ras_push`=1, alone):
  - Write `pc` at top+1 and advance top.
  - `ras_count` increments, saturating at `RAS_DEPTH`.
  - When full, the push overwrites the oldest entry.
- Pop (`pc_src`=100, `pc_write`=1, no `exc_req`, alone):
  - If `ras_count`>0, top retreats and `ras_count` decrements.
  - If empty, there is no state change; the fallback target is used.
- Push and pop in the same cycle:
  - `next_pc` uses the old top.
  - The top entry is replaced with `pc`; `ras_count` is unchanged.
  - If the RAS was empty, this acts as a push only (`ras_count`=1).
- `exc_req` suppresses any pop in that cycle; a simultaneous `ras_push` is still honored.
- `misaligned` is advisory only; the block does not trap on it. The control FSM raises `exc_req` if required.

## Timing
- Reset (`rst` high at an edge) sets: `pc`=`RESET_PC`, `epc`=0, `ras_count`=0, top pointer=0. RAS entry contents are don't-care.
- `rst` has priority over every other input. Reset mid-sequence discards all RAS contents and the pending exception.
- Combinational outputs: `next_pc` and `misaligned` respond to inputs with zero-cycle latency.
- Registered outputs: `ras_empty`, `ras_full` and `ras_count` derive from registered state.
- Register updates are visible one cycle after the enabling edge:
  - `pc` after `pc_write`/`exc_req`.
  - `epc` and the RAS after push/pop/exception.
- No handshake; the control FSM guarantees each enable is asserted for exactly one cycle per event.
- All address arithmetic is 32-bit. RAS pointer arithmetic wraps modulo `RAS_DEPTH`.

## Test plan
- Reset and increment:
  - `rst`=1 for 1 cycle → `pc`=0, `ras_empty`=1.
  - Then `pc_src`=000, `alu_out`=4, `pc_write`=1 → `pc`=4 next cycle.
  - With `pc_write`=0 → `pc` holds 4.
- Jump: `pc`=32'h4000_0010, `jump_addr`=26'h0000100, `pc_src`=010, `pc_write`=1 → `pc`=32'h4000_0400.
- RAS normal call/return:
  - Push at `pc`=0x10, then push at `pc`=0x20 → `ras_count`=2.
  - Pop → `pc`=0x20, then pop → `pc`=0x10, `ras_empty`=1.
  - Pop on empty with `rs_data`=0x88 → `pc`=0x88, `ras_count` stays 0.
- RAS overflow (`RAS_DEPTH`=4): push 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_full`=1, `ras_count`=4. Four pops return 0x50, 0x40, 0x30, 0x20; the fifth pop falls back to `rs_data`.
- Simultaneous push and pop:
  - RAS holds [0x10], `pc`=0x60 → `next_pc`=0x10, top becomes 0x60, `ras_count`=1.
  - Same stimulus on an empty RAS with `rs_data`=0x70 → `next_pc`=0x70, `ras_count`=1, top=0x60.
- Exception and return:
  - `pc`=0x24, `exc_req`=1 with `pc_write`=0 and `pc_src`=100 → `pc`=0x180, `epc`=0x24, no pop.
  - Later `pc_src`=110, `pc_write`=1 → `pc`=0x24.
  - `rs_data`=0x26 with `pc_src`=011 → `misaligned`=1.
